// File: rtl/tone_envelope_gen_if.sv
// Tone generator signal bundle: note frequency in, PCM sample / oscillator status out.
// pwm_out exists only when TONE_PWM_EN is defined.
interface tone_envelope_gen_if;
  logic [8:0] frequency;
  logic [7:0] sample;
  logic       sample_valid;
  logic       square_out;
  logic       note_active;
`ifdef TONE_PWM_EN
  logic       pwm_out;

  modport master (output frequency,
                  input  sample, sample_valid, square_out, note_active, pwm_out);
  modport slave  (input  frequency,
                  output sample, sample_valid, square_out, note_active, pwm_out);
`else
  modport master (output frequency,
                  input  sample, sample_valid, square_out, note_active);
  modport slave  (input  frequency,
                  output sample, sample_valid, square_out, note_active);
`endif
endinterface

// File: rtl/tone_envelope_gen.sv
// Square-wave tone generator with attack/sustain/release envelope, 8-bit PCM out.
// Optional macro TONE_PWM_EN adds a registered PWM rendering of the sample on bus.pwm_out.
module tone_envelope_gen #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned SAMPLE_HZ    = 48000,
  parameter int unsigned ACC_W        = 24,
  parameter int unsigned PHASE_K      = 350,
  parameter int unsigned ATTACK_STEP  = 4,
  parameter int unsigned RELEASE_STEP = 1
) (
  input logic               clk,
  input logic               reset,
  tone_envelope_gen_if.slave bus
);
  localparam int unsigned DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t           state;
  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic [8:0]       freq_r, active_freq, pend_freq, pend_nf;
  logic             pend_v, pend_nv;
  logic [ACC_W-1:0] acc, inc, acc_sum, acc_nx;
  logic             wrap;
  logic [7:0]       env, env_nx, half, sample_nx, sample_r;
  logic [8:0]       env_up;
  logic             sample_valid_r, note_active_r;

  always_comb begin
    tick = (div_cnt == DIV_LAST);
    inc  = ACC_W'(active_freq) * ACC_W'(PHASE_K);
    {wrap, acc_sum} = {1'b0, acc} + {1'b0, inc};
    env_up = {1'b0, env} + 9'(ATTACK_STEP);

    env_nx = env;
    unique case (state)
      IDLE:    env_nx = '0;
      ATTACK:  env_nx = env_up[8] ? '1 : env_up[7:0];
      SUSTAIN: env_nx = '1;
      RELEASE: env_nx = (env < 8'(RELEASE_STEP)) ? '0 : env - 8'(RELEASE_STEP);
    endcase

    acc_nx = (state == IDLE) ? '0 : acc_sum;
    if (state == RELEASE && freq_r == '0 && env_nx == '0)
      acc_nx = '0;

    // Latest differing request wins; returning to the playing pitch cancels it.
    pend_nv = pend_v;
    pend_nf = pend_freq;
    if (state != IDLE && freq_r != '0) begin
      if (freq_r != active_freq) begin
        pend_nv = 1'b1;
        pend_nf = freq_r;
      end else begin
        pend_nv = 1'b0;
      end
    end

    half      = env_nx >> 1;
    sample_nx = acc_nx[ACC_W-1] ? 8'd128 + half : 8'd128 - half;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      freq_r         <= '0;
      active_freq    <= '0;
      pend_freq      <= '0;
      pend_v         <= 1'b0;
      acc            <= '0;
      env            <= '0;
      sample_r       <= 8'd128;
      sample_valid_r <= 1'b0;
      note_active_r  <= 1'b0;
    end else begin
      freq_r         <= bus.frequency;
      div_cnt        <= tick ? '0 : div_cnt + 1'b1;
      sample_valid_r <= tick;
      pend_v         <= pend_nv;
      pend_freq      <= pend_nf;

      if (tick) begin
        env      <= env_nx;
        acc      <= acc_nx;
        sample_r <= sample_nx;
        // Pitch switches only at the carry so the current period completes.
        if (state != IDLE && wrap && pend_nv) begin
          active_freq <= pend_nf;
          pend_v      <= 1'b0;
        end
      end

      unique case (state)
        IDLE:
          if (freq_r != '0) begin
            state         <= ATTACK;
            note_active_r <= 1'b1;
            active_freq   <= freq_r;
            acc           <= '0;
            pend_v        <= 1'b0;
          end
        ATTACK:
          if (freq_r == '0)
            state <= RELEASE;
          else if (tick && env_nx == '1)
            state <= SUSTAIN;
        SUSTAIN:
          if (freq_r == '0)
            state <= RELEASE;
        RELEASE:
          if (freq_r != '0)
            state <= ATTACK;
          else if (tick && env_nx == '0) begin
            state         <= IDLE;
            note_active_r <= 1'b0;
            pend_v        <= 1'b0;
          end
      endcase
    end
  end

  assign bus.sample       = sample_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.square_out   = acc[ACC_W-1];
  assign bus.note_active  = note_active_r;

`ifdef TONE_PWM_EN
  logic [7:0] pwm_cnt;
  logic       pwm_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_r   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_r   <= (pwm_cnt < sample_r);
    end
  end

  assign bus.pwm_out = pwm_r;
`endif
endmodule

// File: tb/tb_tone_envelope_gen.sv
// Bench for tone_envelope_gen: tick-level reference model feeding a sample scoreboard,
// a table of envelope vectors, and hand-written reset/pitch/glitch sequences.
module tb_tone_envelope_gen;
  localparam int unsigned CLK_HZ    = 144000;
  localparam int unsigned SAMPLE_HZ = 48000;
  localparam int          DIV       = 3;
  localparam int          PK        = 350;
  localparam longint      MOD       = 64'd16777216;
  localparam int M_IDLE = 0, M_ATK = 1, M_SUS = 2, M_REL = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tone_envelope_gen_if bus();

  tone_envelope_gen #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .ACC_W(24), .PHASE_K(PK),
    .ATTACK_STEP(4), .RELEASE_STEP(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int freq;
    int ticks;
    int exp_active;
    int exp_amp;
  } vec_t;

  vec_t   vecs[14];
  int     exp_q[$];
  int     checks = 0, failures = 0;
  int     bcnt = 0;
  bit     exp_sv = 1'b0;
  int     m_st, m_env, m_af, m_pf;
  bit     m_pv;
  longint m_acc;
  int     len, total, n329;
  bit     found, prev, first;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int amp(input int s);
    return (s >= 128) ? s - 128 : 128 - s;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_env = 0; m_af = 0; m_pf = 0; m_pv = 0; m_acc = 0;
  endtask

  // One envelope/oscillator step, using the frequency the DUT has registered.
  task automatic model_tick(input int f);
    longint s;
    int sq;
    if (m_st == M_IDLE) begin
      if (f != 0) begin m_af = f; m_acc = 0; m_st = M_ATK; m_pv = 0; end
    end else if (f == 0) begin
      m_st = M_REL;
      if (m_st == M_REL && m_env == 0) m_st = M_REL;
    end else begin
      if (m_st == M_REL) m_st = M_ATK;
      if (f != m_af) begin m_pf = f; m_pv = 1; end
      else m_pv = 0;
    end
    case (m_st)
      M_IDLE: m_env = 0;
      M_ATK:  m_env = (m_env + 4 > 255) ? 255 : m_env + 4;
      M_SUS:  m_env = 255;
      default: m_env = (m_env < 1) ? 0 : m_env - 1;
    endcase
    if (m_st != M_IDLE) begin
      s = m_acc + longint'(m_af) * PK;
      if (s >= MOD) begin
        s = s - MOD;
        if (m_pv) begin m_af = m_pf; m_pv = 0; end
      end
      m_acc = s;
    end
    if (m_st == M_ATK && m_env == 255) m_st = M_SUS;
    else if (m_st == M_REL && m_env == 0) begin m_st = M_IDLE; m_acc = 0; m_pv = 0; end
    sq = int'((m_acc >> 23) & 1);
    exp_q.push_back((sq << 8) | (sq ? 128 + (m_env >> 1) : 128 - (m_env >> 1)));
  endtask

  // Advance to the next falling edge; score any sample due this cycle.
  task automatic cyc();
    int e;
    @(negedge clk);
    if (exp_sv) begin
      chk("sample_valid", int'(bus.sample_valid), 1);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty actual=0 expected=1");
      end else begin
        e = exp_q.pop_front();
        chk("sample", int'(bus.sample), e & 255);
        chk("square_out", int'(bus.square_out), e >> 8);
      end
    end else begin
      chk("sample_valid_idle", int'(bus.sample_valid), 0);
    end
    exp_sv = 1'b0;
    if (bcnt == DIV - 1) begin
      model_tick(int'(bus.frequency));
      exp_sv = 1'b1;
    end
    bcnt = (bcnt == DIV - 1) ? 0 : bcnt + 1;
  endtask

  // Run n ticks plus the cycle that presents the last sample.
  task automatic wait_ticks(input int n);
    int t;
    t = 0;
    while (t < n) begin
      cyc();
      if (exp_sv) t++;
    end
    cyc();
  endtask

  task automatic do_reset();
    bus.frequency = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_sample", int'(bus.sample), 128);
    chk("rst_square", int'(bus.square_out), 0);
    chk("rst_active", int'(bus.note_active), 0);
    chk("rst_valid", int'(bus.sample_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    exp_sv = 1'b0;
    bcnt = 1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0,   4,   0, 0};
    vecs[1]  = '{440, 63,  1, 126};
    vecs[2]  = '{440, 1,   1, 127};
    vecs[3]  = '{440, 10,  1, 127};
    vecs[4]  = '{0,   100, 1, 77};
    vecs[5]  = '{0,   154, 1, 0};
    vecs[6]  = '{0,   1,   0, 0};
    vecs[7]  = '{0,   3,   0, 0};
    vecs[8]  = '{523, 30,  1, 60};
    vecs[9]  = '{0,   20,  1, 50};
    vecs[10] = '{349, 38,  1, 126};
    vecs[11] = '{349, 1,   1, 127};
    vecs[12] = '{349, 5,   1, 127};
    vecs[13] = '{0,   255, 0, 0};

    bus.frequency = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    wait_ticks(1);
    chk("first_sample", int'(bus.sample), 128);

    for (int i = 0; i < 14; i++) begin
      bus.frequency = 9'(vecs[i].freq);
      wait_ticks(vecs[i].ticks);
      chk($sformatf("vec%0d_active", i), int'(bus.note_active), vecs[i].exp_active);
      chk($sformatf("vec%0d_amp", i), amp(int'(bus.sample)), vecs[i].exp_amp);
    end

    // Reset in the middle of an attack
    bus.frequency = 9'd440;
    wait_ticks(10);
    chk("attack_env40_amp", amp(int'(bus.sample)), 20);
    do_reset();
    wait_ticks(1);
    chk("post_abort_sample", int'(bus.sample), 128);
    chk("post_abort_active", int'(bus.note_active), 0);

    // Full attack then pitch measurement at 440 Hz
    bus.frequency = 9'd440;
    wait_ticks(64);
    chk("attack64_amp", amp(int'(bus.sample)), 127);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      prev = bus.square_out;
      wait_ticks(1);
      if (!prev && bus.square_out) found = 1'b1;
    end
    chk("first_rise", int'(found), 1);
    total = 0;
    for (int p = 0; p < 100; p++) begin
      len = 0;
      found = 1'b0;
      while (!found && len < 300) begin
        prev = bus.square_out;
        wait_ticks(1);
        len++;
        if (!prev && bus.square_out) found = 1'b1;
      end
      chk_rng("period_440", len, 108, 109);
      total += len;
    end
    chk_rng("total_100_periods", total, 10893, 10895);

    // Pitch change 261 -> 329 while sustaining
    bus.frequency = 9'd261;
    wait_ticks(400);
    prev = bus.square_out;
    len = 0; first = 1'b1; n329 = 0;
    for (int k = 0; k < 700; k++) begin
      if (k == 150) bus.frequency = 9'd329;
      wait_ticks(1);
      len++;
      if (bus.square_out != prev) begin
        if (!first) begin
          chk_rng("half_period_min", len, 25, 200);
          chk("half_period_len", int'(len inside {72, 73, 91, 92}), 1);
          if (len <= 73) n329++;
        end
        first = 1'b0;
        len = 0;
        prev = bus.square_out;
      end
    end
    chk("halves_at_329", int'(n329 >= 3), 1);

    // Release to silence
    bus.frequency = '0;
    wait_ticks(300);
    chk("final_active", int'(bus.note_active), 0);
    chk("final_sample", int'(bus.sample), 128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tone_envelope_gen.md
Name: tone_envelope_gen

Overview:
- Downstream consumer of the PS/2 keyboard decoder's 9-bit note frequency in Hz (0 = no key).
- Converts the frequency into a square-wave tone with a phase accumulator clocked at a fixed audio sample rate.
- Applies an attack/sustain/release amplitude envelope.
- Emits unsigned 8-bit PCM samples with a one-cycle valid strobe, for the audio output stage.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- SAMPLE_HZ, 48000, sample rate; tick divider DIV = CLK_HZ/SAMPLE_HZ (integer floor, 1041 at defaults).
- ACC_W, 24, phase accumulator width.
- PHASE_K, 350, phase increment per Hz = round(2^ACC_W/SAMPLE_HZ).
- ATTACK_STEP, 4, envelope increment per tick in ATTACK.
- RELEASE_STEP, 1, envelope decrement per tick in RELEASE.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high reset.
- frequency, input, 9, requested note in Hz; 0 = note off; may change on any cycle.
- sample, output, 8, unsigned PCM, midscale 128.
- sample_valid, output, 1, one-cycle pulse per new sample.
- square_out, output, 1, raw oscillator MSB.
- note_active, output, 1, high when the state is not IDLE.

Behaviour:
- Reset, asynchronous and active-high:
  - state = IDLE; acc, env, tick counter and active_freq cleared.
  - sample = 128; sample_valid = 0; square_out = 0; note_active = 0.
  - Reset mid-note aborts immediately; no release.
- Tick generation:
  - The divider counts 0..DIV-1.
  - tick is high for one cycle at DIV-1, then the counter wraps to 0.
  - All oscillator and envelope updates happen only on tick cycles.
- Oscillator:
  - inc = active_freq*PHASE_K, computed at ACC_W width; no overflow for frequency <= 511.
  - On each tick, acc <= acc + inc mod 2^ACC_W.
  - wrap = carry out of that addition.
  - square_out = acc[ACC_W-1].
- Frequency handling:
  - frequency is registered each cycle.
  - In IDLE, a nonzero frequency loads active_freq directly, clears acc and enters ATTACK.
  - In other states, a nonzero frequency different from active_freq is held as pending.
  - pending is copied to active_freq on the tick that produces a wrap, so no truncated half-period occurs.
  - The new increment takes effect from the following tick.
  - If pending changes again before a wrap, the latest value wins.
- Envelope FSM (env is 8 bits, saturating):
  - IDLE: env = 0; acc held at 0.
  - ATTACK: env = min(255, env+ATTACK_STEP) per tick; go to SUSTAIN when env reaches 255.
  - SUSTAIN: env = 255.
  - frequency = 0 in ATTACK or SUSTAIN -> RELEASE.
  - RELEASE: env = max(0, env-RELEASE_STEP) per tick; the oscillator keeps running at active_freq.
  - env reaching 0 -> IDLE (acc cleared, pending discarded).
  - Nonzero frequency in RELEASE -> ATTACK starting from the current env, with no reset to 0; a frequency change follows the pending/wrap rule.
  - Transition and update on the same tick: a state change evaluated on tick T takes effect for the envelope update at tick T+1.
- Output:
  - On the cycle after a tick, sample <= square_out ? 128+(env>>1) : 128-(env>>1), computed from the post-tick acc and env.
  - sample_valid = 1 for that same single cycle.
  - Range is 1..255. In IDLE, sample = 128.
  - Latency: from a frequency change to the first affected sample_valid is at most 1 register cycle + 1 tick + 1 cycle.

Optional Feature:
- Macro: TONE_PWM_EN.
- Defined:
  - Adds output port pwm_out (1 bit).
  - An 8-bit free-running counter increments every clk and is cleared by reset.
  - pwm_out = (pwm_cnt < sample), registered; reset value 0.
  - In IDLE this gives a 50% duty cycle (128/256).
- Undefined: no pwm_out port and no counter; all other behaviour is identical.

Test Plan:
- Reset: assert reset during ATTACK at env=40 -> the same cycle shows sample=128, square_out=0, note_active=0, sample_valid=0; after release, the first sample_valid reads 128.
- Attack: frequency=440 from IDLE -> note_active=1; env reaches 255 after exactly 64 ticks; the 64th post-tick sample is 255 or 1; state SUSTAIN.
- Pitch: frequency=440 held in SUSTAIN -> inc=154000; 100 consecutive square_out periods each measure 108 or 109 ticks; total 10894±1 ticks.
- Glitch-free change: 261->329 in SUSTAIN -> inc switches from 91350 to 115150 only on the tick after the next wrap; no square_out half-period shorter than 25 ticks.
- Release: frequency=0 in SUSTAIN -> exactly 255 ticks until IDLE; note_active falls; subsequent samples are 128.
- Retrigger: frequency=349 at env=100 during RELEASE -> ATTACK from 100; SUSTAIN reached after 39 ticks; the new pitch applies only after the next wrap.
